// File: rtl/coh_noc_cfg_apb_bridge_if.sv
// rtl/coh_noc_cfg_apb_bridge_if.sv - APB4 completer-side bus bundle for the config bridge
//
// Purpose: groups the APB request/response signals seen by coh_noc_cfg_apb_bridge.
// Signals:
//   psel, penable, pwrite  APB select / enable / direction (1 = write)
//   paddr[15:0]            APB byte address
//   pwdata[31:0]           APB write data
//   prdata[31:0]           APB read data, valid when pready=1
//   pready                 APB ready
//   pslverr                APB error, valid when pready=1
// Modports: master = APB requester (host), slave = APB completer (bridge).

interface coh_noc_cfg_apb_bridge_if;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    input  prdata,
    input  pready,
    input  pslverr
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    output prdata,
    output pready,
    output pslverr
  );

endinterface

// File: rtl/coh_noc_cfg_apb_bridge.sv
// rtl/coh_noc_cfg_apb_bridge.sv - APB4 completer to CoH NoC configuration bus bridge
//
// Purpose: turns each APB access into one config-bus operation, waits for
// cfg_ready, and returns the result. Misaligned accesses and writes to
// non-exempt addresses while config_locked=1 are rejected at decode; every
// access that reaches the config bus is bounded by TIMEOUT_CYCLES wait cycles.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   apb                APB completer bundle (coh_noc_cfg_apb_bridge_if.slave)
//   cfg_write          config write strobe (one cycle per write)
//   cfg_addr[15:0]     config address, held between accesses
//   cfg_wdata[31:0]    config write data, held between accesses
//   cfg_rdata[31:0]    config read data, valid while cfg_ready=1
//   cfg_ready          config bus ready
//   config_locked      configuration locked status, sampled at decode only
//
// Optional feature macro COH_NOC_CFG_BRIDGE_STATS_EN adds:
//   stat_clear              synchronous clear of all counters
//   stat_wr_count[15:0]     successful writes (saturating)
//   stat_rd_count[15:0]     successful reads (saturating)
//   stat_err_count[15:0]    errored responses and aborts (saturating)

module coh_noc_cfg_apb_bridge #(
  parameter int          TIMEOUT_CYCLES   = 64,
  parameter logic [15:0] LOCK_EXEMPT_ADDR = 16'h0000,
  parameter logic [31:0] ERR_RDATA        = 32'hDEAD_C0DE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  coh_noc_cfg_apb_bridge_if.slave      apb,
  output logic                         cfg_write,
  output logic [15:0]                  cfg_addr,
  output logic [31:0]                  cfg_wdata,
  input  logic [31:0]                  cfg_rdata,
  input  logic                         cfg_ready,
  input  logic                         config_locked
`ifdef COH_NOC_CFG_BRIDGE_STATS_EN
  ,
  input  logic                         stat_clear,
  output logic [15:0]                  stat_wr_count,
  output logic [15:0]                  stat_rd_count,
  output logic [15:0]                  stat_err_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic [7:0]  tmo_cnt;
  logic        is_write;
  logic [31:0] prdata_q;
  logic        pready_q;
  logic        pslverr_q;

  logic        access;
  logic        dec_err;
  logic        abort;
  logic [7:0]  tmo_cnt_nxt;

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;

  assign access      = apb.psel && apb.penable;
  assign dec_err     = (apb.paddr[1:0] != 2'b00) ||
                       (apb.pwrite && config_locked && (apb.paddr != LOCK_EXEMPT_ADDR));
  // Dropping psel mid-operation is a protocol violation; the access is dropped silently.
  assign abort       = ((state == ST_ISSUE) || (state == ST_WAIT)) && !apb.psel;
  assign tmo_cnt_nxt = tmo_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmo_cnt   <= 8'd0;
      is_write  <= 1'b0;
      prdata_q  <= 32'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      cfg_write <= 1'b0;
      cfg_addr  <= 16'd0;
      cfg_wdata <= 32'd0;
    end else begin
      // Strobe-like outputs default low; each branch raises them for exactly one cycle.
      cfg_write <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (access) begin
            cfg_addr  <= apb.paddr;
            cfg_wdata <= apb.pwdata;
            is_write  <= apb.pwrite;
            if (dec_err) begin
              state     <= ST_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= apb.pwrite ? 32'd0 : ERR_RDATA;
            end else begin
              state     <= ST_ISSUE;
              cfg_write <= apb.pwrite;
            end
          end
        end

        ST_ISSUE: begin
          tmo_cnt <= 8'd0;
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (cfg_ready) begin
            // A ready sample on the last permitted wait cycle still completes cleanly.
            state     <= ST_RESP;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b0;
            prdata_q  <= is_write ? 32'd0 : cfg_rdata;
          end else begin
            tmo_cnt <= tmo_cnt_nxt;
            if (tmo_cnt_nxt == TMO_LIMIT) begin
              state     <= ST_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= is_write ? 32'd0 : ERR_RDATA;
            end
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef COH_NOC_CFG_BRIDGE_STATS_EN
  logic resp_ok_wr;
  logic resp_ok_rd;
  logic resp_err;

  // pslverr_q is high throughout RESP exactly when the response is an error.
  assign resp_ok_wr = (state == ST_RESP) && !pslverr_q && is_write;
  assign resp_ok_rd = (state == ST_RESP) && !pslverr_q && !is_write;
  assign resp_err   = ((state == ST_RESP) && pslverr_q) || abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_count  <= 16'd0;
      stat_rd_count  <= 16'd0;
      stat_err_count <= 16'd0;
    end else if (stat_clear) begin
      stat_wr_count  <= 16'd0;
      stat_rd_count  <= 16'd0;
      stat_err_count <= 16'd0;
    end else begin
      if (resp_ok_wr && (stat_wr_count != 16'hFFFF)) begin
        stat_wr_count <= stat_wr_count + 16'd1;
      end
      if (resp_ok_rd && (stat_rd_count != 16'hFFFF)) begin
        stat_rd_count <= stat_rd_count + 16'd1;
      end
      if (resp_err && (stat_err_count != 16'hFFFF)) begin
        stat_err_count <= stat_err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_coh_noc_cfg_apb_bridge.sv
// tb/tb_coh_noc_cfg_apb_bridge.sv - self-checking bench for coh_noc_cfg_apb_bridge

module tb_coh_noc_cfg_apb_bridge;

  localparam int          TMO    = 4;
  localparam logic [15:0] EXEMPT = 16'h0000;
  localparam logic [31:0] ERRD   = 32'hDEAD_C0DE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_write;
  logic [15:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata = 32'd0;
  logic        cfg_ready = 1'b0;
  logic        config_locked = 1'b0;

  coh_noc_cfg_apb_bridge_if bus ();

  coh_noc_cfg_apb_bridge #(
    .TIMEOUT_CYCLES  (TMO),
    .LOCK_EXEMPT_ADDR(EXEMPT),
    .ERR_RDATA       (ERRD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apb          (bus),
    .cfg_write    (cfg_write),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .cfg_ready    (cfg_ready),
    .config_locked(config_locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model: timeline of expected events keyed by cycle number.
  bit          exp_rdy[int];
  logic        exp_err[int];
  logic [31:0] exp_rd[int];
  bit          exp_cw[int];
  logic [15:0] m_addr = 16'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [15:0] pend_addr;
  logic [31:0] pend_wdata;
  int          upd_cyc = -1;
  bit          chk_en = 1'b0;
  int          cw_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every output against the model timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == upd_cyc) begin
        m_addr  = pend_addr;
        m_wdata = pend_wdata;
      end
      check("pready", 32'(bus.pready), 32'(exp_rdy.exists(cyc)));
      if (exp_rdy.exists(cyc)) begin
        check("pslverr", 32'(bus.pslverr), 32'(exp_err[cyc]));
        check("prdata", bus.prdata, exp_rd[cyc]);
      end else begin
        check("pslverr_idle", 32'(bus.pslverr), 32'd0);
      end
      check("cfg_write", 32'(cfg_write), 32'(exp_cw.exists(cyc)));
      check("cfg_addr", 32'(cfg_addr), 32'(m_addr));
      check("cfg_wdata", cfg_wdata, m_wdata);
      if (cfg_write) cw_pulses++;
    end
  end

  // Expected timeline for an access whose access-phase cycle is c0. d = number of
  // wait cycles with cfg_ready low before it rises.
  task automatic plan(input logic [15:0] addr, input logic [31:0] data, input bit wr,
                      input bit locked, input int d, input logic [31:0] rdata,
                      input bit no_resp, input int c0);
    bit derr;
    int r;
    pend_addr  = addr;
    pend_wdata = data;
    upd_cyc    = c0 + 1;
    derr = (addr[1:0] != 2'b00) || (wr && locked && addr != EXEMPT);
    if (derr) begin
      r = c0 + 1;
      exp_rdy[r] = 1'b1;
      exp_err[r] = 1'b1;
      exp_rd[r]  = wr ? 32'd0 : ERRD;
    end else begin
      if (wr) exp_cw[c0 + 1] = 1'b1;
      if (!no_resp) begin
        if (d < TMO) begin
          r = c0 + 3 + d;
          exp_rdy[r] = 1'b1;
          exp_err[r] = 1'b0;
          exp_rd[r]  = wr ? 32'd0 : rdata;
        end else begin
          r = c0 + 2 + TMO;
          exp_rdy[r] = 1'b1;
          exp_err[r] = 1'b1;
          exp_rd[r]  = wr ? 32'd0 : ERRD;
        end
      end
    end
  endtask

  task automatic start_access(input logic [15:0] addr, input logic [31:0] data, input bit wr,
                              input bit locked, input logic [31:0] rdata, output int c0);
    @(negedge clk);
    bus.psel      = 1'b1;
    bus.penable   = 1'b0;
    bus.pwrite    = wr;
    bus.paddr     = addr;
    bus.pwdata    = data;
    config_locked = locked;
    cfg_rdata     = rdata;
    cfg_ready     = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    c0 = cyc;
  endtask

  task automatic access(input logic [15:0] addr, input logic [31:0] data, input bit wr,
                        input bit locked, input int d, input logic [31:0] rdata,
                        output int lat, output logic err, output logic [31:0] rd);
    int c0;
    bit done;
    start_access(addr, data, wr, locked, rdata, c0);
    plan(addr, data, wr, locked, d, rdata, 1'b0, c0);
    lat  = -1;
    err  = 1'bx;
    rd   = 32'hx;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (bus.pready) begin
        lat  = cyc - c0;
        err  = bus.pslverr;
        rd   = bus.prdata;
        done = 1'b1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        cfg_ready   = 1'b0;
      end else begin
        cfg_ready = (cyc >= c0 + 2 + d);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: no pready within 40 cycles for addr %h", addr);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
    end
  endtask

  int          lat;
  logic        err;
  logic [31:0] rd;
  int          p0;
  int          c0;

  initial begin
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 16'd0;
    bus.pwdata  = 32'd0;

    repeat (3) @(negedge clk);
    check("rst_prdata", bus.prdata, 32'd0);
    check("rst_pready", 32'(bus.pready), 32'd0);
    check("rst_pslverr", 32'(bus.pslverr), 32'd0);
    check("rst_cfg_write", 32'(cfg_write), 32'd0);
    check("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    check("rst_cfg_wdata", cfg_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Clean write, cfg_ready high from the first wait cycle.
    p0 = cw_pulses;
    access(16'h0010, 32'h0000_0404, 1'b1, 1'b0, 0, 32'd0, lat, err, rd);
    check("wr_latency", lat, 32'd3);
    check("wr_err", 32'(err), 32'd0);
    check("wr_pulses", cw_pulses - p0, 32'd1);

    // Read with cfg_ready rising after two wait cycles.
    p0 = cw_pulses;
    access(16'h0020, 32'h0, 1'b0, 1'b0, 2, 32'h1234_5678, lat, err, rd);
    check("rd_latency", lat, 32'd5);
    check("rd_data", rd, 32'h1234_5678);
    check("rd_err", 32'(err), 32'd0);
    check("rd_pulses", cw_pulses - p0, 32'd0);

    // Misaligned write and misaligned read.
    p0 = cw_pulses;
    access(16'h0012, 32'h0000_0055, 1'b1, 1'b0, 0, 32'd0, lat, err, rd);
    check("mis_wr_latency", lat, 32'd1);
    check("mis_wr_err", 32'(err), 32'd1);
    check("mis_wr_pulses", cw_pulses - p0, 32'd0);
    access(16'h0021, 32'h0, 1'b0, 1'b0, 0, 32'h1111_2222, lat, err, rd);
    check("mis_rd_data", rd, 32'hDEAD_C0DE);
    check("mis_rd_err", 32'(err), 32'd1);

    // Locked: non-exempt write rejected, exempt write goes through.
    p0 = cw_pulses;
    access(16'h0030, 32'h0000_0777, 1'b1, 1'b1, 0, 32'd0, lat, err, rd);
    check("lock_wr_err", 32'(err), 32'd1);
    check("lock_wr_latency", lat, 32'd1);
    check("lock_wr_pulses", cw_pulses - p0, 32'd0);
    p0 = cw_pulses;
    access(16'h0000, 32'h0000_0001, 1'b1, 1'b1, 0, 32'd0, lat, err, rd);
    check("exempt_wr_err", 32'(err), 32'd0);
    check("exempt_wr_pulses", cw_pulses - p0, 32'd1);
    config_locked = 1'b0;

    // Timeout read, then ready arriving on the final wait cycle.
    access(16'h0024, 32'h0, 1'b0, 1'b0, 100, 32'h5555_5555, lat, err, rd);
    check("tmo_rd_latency", lat, 32'd6);
    check("tmo_rd_err", 32'(err), 32'd1);
    check("tmo_rd_data", rd, 32'hDEAD_C0DE);
    access(16'h0024, 32'h0, 1'b0, 1'b0, 3, 32'hA5A5_0001, lat, err, rd);
    check("late_rd_latency", lat, 32'd6);
    check("late_rd_err", 32'(err), 32'd0);
    check("late_rd_data", rd, 32'hA5A5_0001);
    access(16'h0028, 32'hCAFE_0000, 1'b1, 1'b0, 100, 32'd0, lat, err, rd);
    check("tmo_wr_err", 32'(err), 32'd1);
    check("tmo_wr_data", rd, 32'd0);

    // Abort: psel dropped during WAIT, no response; next access completes.
    start_access(16'h0034, 32'h0, 1'b0, 1'b0, 32'h0BAD_0BAD, c0);
    plan(16'h0034, 32'h0, 1'b0, 1'b0, 100, 32'd0, 1'b1, c0);
    @(negedge clk);
    @(negedge clk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    repeat (4) @(negedge clk);
    access(16'h0044, 32'h0000_4444, 1'b1, 1'b0, 0, 32'd0, lat, err, rd);
    check("post_abort_latency", lat, 32'd3);
    check("post_abort_err", 32'(err), 32'd0);

    // Reset during WAIT.
    start_access(16'h0040, 32'h0000_0040, 1'b0, 1'b0, 32'd0, c0);
    plan(16'h0040, 32'h0000_0040, 1'b0, 1'b0, 100, 32'd0, 1'b1, c0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_cfg_addr", 32'(cfg_addr), 32'h0000_0040);
    #1;
    chk_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_prdata", bus.prdata, 32'd0);
    check("mid_rst_pready", 32'(bus.pready), 32'd0);
    check("mid_rst_pslverr", 32'(bus.pslverr), 32'd0);
    check("mid_rst_cfg_write", 32'(cfg_write), 32'd0);
    check("mid_rst_cfg_addr", 32'(cfg_addr), 32'd0);
    check("mid_rst_cfg_wdata", cfg_wdata, 32'd0);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    exp_rdy.delete();
    exp_err.delete();
    exp_rd.delete();
    exp_cw.delete();
    upd_cyc = -1;
    m_addr  = 16'd0;
    m_wdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_en = 1'b1;

    access(16'h0008, 32'h0, 1'b0, 1'b0, 0, 32'h0000_8888, lat, err, rd);
    check("post_rst_rd_latency", lat, 32'd3);
    check("post_rst_rd_data", rd, 32'h0000_8888);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
